// File: rtl/tomas_pkg.sv
// Shared definitions for the Tomasulo front-end instruction queue.
//   QUEUE_WIDTH / QUEUE_DEPTH : default entry width and entry count
//   queue_entry_t             : generic entry type; a typed instruction format
//                               may take its place later
//   ptr_inc()                 : circular pointer increment that wraps at depth-1,
//                               so the depth does not have to be a power of two
package tomas_pkg;

  localparam int QUEUE_WIDTH = 16;
  localparam int QUEUE_DEPTH = 8;

  typedef logic [QUEUE_WIDTH-1:0] queue_entry_t;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/queue_ram.sv
// DEPTH x WIDTH storage for inst_queue.
//   clock         : rising-edge write clock
//   we/waddr/wdata: single synchronous write port
//   raddr/rdata   : asynchronous read port (head entry for first-word-fall-through)
// The contents are not reset. Keeping the storage in its own module lets it be
// swapped for a block RAM later without touching the pointer logic.
module queue_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction/operand queue between fetch/decode (producer) and issue (consumer).
// Circular first-word-fall-through FIFO with valid/ready on both sides.
//   clock, reset_n        : clock, asynchronous active-low reset
//   flush                 : synchronous discard of all entries, overrides push/pop
//   in_valid/in_ready/in_data    : producer handshake (in_ready = !full)
//   out_valid/out_ready/out_data : consumer handshake (head visible, 0 when empty)
//   count, full, empty, almost_full : occupancy status, derived from count only
module inst_queue
  import tomas_pkg::*;
#(
  parameter int WIDTH    = QUEUE_WIDTH,
  parameter int DEPTH    = QUEUE_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] head;
  logic             push, pop;

  // Status comes from the count register alone, so in_ready never depends on
  // out_ready in the same cycle: a full queue refuses a push even while popping.
  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_C);
  assign in_ready    = ~full;
  assign out_valid   = ~empty;
  assign out_data    = empty ? '0 : head;

  // Flush swallows any handshake in the same cycle, including the RAM write.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= AW'(ptr_inc(32'(wr_ptr), DEPTH));
      if (pop)  rd_ptr <= AW'(ptr_inc(32'(rd_ptr), DEPTH));
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             full, empty, almost_full;

  int compared   = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] sb[$];   // expected contents, head at index 0
  int               mcount = 0;

  always #5 clock = ~clock;

  inst_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Status/head check against the model.
  task automatic chk_status(input string tag);
    chk({tag, ".count"},       32'(count),       32'(mcount));
    chk({tag, ".empty"},       32'(empty),       32'(mcount == 0));
    chk({tag, ".full"},        32'(full),        32'(mcount == DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(mcount >= AF));
    chk({tag, ".in_ready"},    32'(in_ready),    32'(mcount != DEPTH));
    chk({tag, ".out_valid"},   32'(out_valid),   32'(mcount != 0));
    chk({tag, ".out_data"},    32'(out_data),    (mcount == 0) ? 32'd0 : 32'(sb[0]));
  endtask

  // One clock cycle of stimulus, called 1 time unit after a rising edge.
  task automatic cyc(input string tag, input logic iv, input logic [WIDTH-1:0] d,
                     input logic ordy, input logic fl);
    logic exp_push, exp_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk_status({tag, ".pre"});
    exp_push = iv && (mcount < DEPTH) && !fl;
    exp_pop  = ordy && (mcount > 0) && !fl;
    if (fl) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (exp_pop)  void'(sb.pop_front());
      if (exp_push) sb.push_back(d);
      mcount = mcount + int'(exp_push) - int'(exp_pop);
    end
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    chk_status({tag, ".post"});
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk_status("reset");

    // Fill 1..8, then a refused 9th push.
    for (int i = 1; i <= 8; i++) cyc("fill", 1'b1, WIDTH'(i), 1'b0, 1'b0);
    cyc("fill9", 1'b1, 16'h0009, 1'b0, 1'b0);

    // Drain in order.
    for (int i = 0; i < 8; i++) cyc("drain", 1'b0, '0, 1'b1, 1'b0);

    // Wrap and concurrency.
    for (int i = 0; i < 5; i++) cyc("wpush", 1'b1, WIDTH'(16'h0100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("wpop", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc("wboth", 1'b1, WIDTH'(16'h0200 + i), 1'b1, 1'b0);
    chk("wrap.count2", 32'(count), 32'd2);

    // Full with simultaneous pop: 0xBEEF refused.
    for (int i = 0; i < 6; i++) cyc("refill", 1'b1, WIDTH'(16'h0300 + i), 1'b0, 1'b0);
    chk("full.reached", 32'(full), 32'd1);
    cyc("fullpop", 1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("fullpop.count7", 32'(count), 32'd7);

    // Down to 4, then flush with both handshakes requested.
    for (int i = 0; i < 3; i++) cyc("to4", 1'b0, '0, 1'b1, 1'b0);
    chk("flush.pre4", 32'(count), 32'd4);
    cyc("flush", 1'b1, 16'h1234, 1'b1, 1'b1);
    cyc("after_flush", 1'b0, '0, 1'b1, 1'b0);

    // Refill two and hit reset between edges.
    cyc("pre_rst", 1'b1, 16'hA001, 1'b0, 1'b0);
    cyc("pre_rst", 1'b1, 16'hA002, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    sb.delete();
    mcount = 0;
    #1;
    chk_status("async_rst");
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    cyc("post_rst", 1'b1, 16'h5A5A, 1'b0, 1'b0);
    cyc("post_rst", 1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
